// File: rtl/pool2d_stream.sv
// pool2d_stream
// Streaming 2-D pooling layer that takes one signed pixel per cycle in raster
// order. It pools non-overlapping KxK windows (stride K) in either average or
// max mode. It emits one pooled pixel per completed window, tagged with its
// output row and column.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset (wins over enable)
//   enable      global enable; when low, input is ignored and state holds
//   mode        0 = average, 1 = max; latched on the first pixel of a frame
//   in_valid    in_data carries a pixel this cycle
//   in_data     signed input pixel
//   out_valid   one-cycle strobe: out_data/out_row/out_col are new
//   out_data    signed pooled pixel
//   out_row     output row index of out_data
//   out_col     output column index of out_data
//   frame_done  one-cycle pulse with the last output of a frame
//   busy        high from the first accepted pixel of a frame until frame_done
module pool2d_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 2,
    localparam int OUT_W = IMG_W / K,
    localparam int OUT_H = IMG_H / K
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         enable,
    input  logic                                         mode,
    input  logic                                         in_valid,
    input  logic signed [DATA_W-1:0]                     in_data,
    output logic                                         out_valid,
    output logic signed [DATA_W-1:0]                     out_data,
    output logic [((OUT_H > 1) ? $clog2(OUT_H) : 1)-1:0] out_row,
    output logic [((OUT_W > 1) ? $clog2(OUT_W) : 1)-1:0] out_col,
    output logic                                         frame_done,
    output logic                                         busy
);

    localparam int LOG2K  = $clog2(K);
    localparam int SHIFT  = 2 * LOG2K;
    localparam int ACC_W  = DATA_W + SHIFT;
    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int OCOL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int OROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    if ((K < 1) || ((K & (K - 1)) != 0) || ((IMG_W % K) != 0) || ((IMG_H % K) != 0)) begin : g_bad_params
        $fatal(1, "pool2d_stream: K must be a power of two that divides IMG_W and IMG_H");
    end

    logic [COL_W-1:0]         col_q, col_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic                     mode_q, mode_d;
    logic signed [ACC_W-1:0]  acc_q [OUT_W];
    logic signed [ACC_W-1:0]  acc_d [OUT_W];
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic [OROW_W-1:0]        out_row_q, out_row_d;
    logic [OCOL_W-1:0]        out_col_q, out_col_d;
    logic                     frame_done_q, frame_done_d;
    logic                     busy_q, busy_d;

    logic                     accept;
    logic                     at_origin;
    logic                     win_first;
    logic                     win_last;
    logic                     frame_last;
    logic                     cur_mode;
    logic [OCOL_W-1:0]        win_col;
    logic [OROW_W-1:0]        win_row;
    logic signed [ACC_W-1:0]  pix_ext;
    logic signed [ACC_W-1:0]  acc_sel;
    logic signed [ACC_W-1:0]  win_val;
    logic signed [ACC_W-1:0]  win_avg;

    // Position of the incoming pixel inside its pooling window.
    always_comb begin
        accept     = enable && in_valid;
        at_origin  = (col_q == '0) && (row_q == '0);
        win_first  = ((int'(col_q) % K) == 0) && ((int'(row_q) % K) == 0);
        win_last   = ((int'(col_q) % K) == K - 1) && ((int'(row_q) % K) == K - 1);
        frame_last = (col_q == COL_W'(IMG_W - 1)) && (row_q == ROW_W'(IMG_H - 1));
        win_col    = OCOL_W'(int'(col_q) / K);
        win_row    = OROW_W'(int'(row_q) / K);
    end

    // The first pixel of a frame uses the live mode input, because the latch
    // only captures it on that same edge.
    // The first pixel of a window replaces the accumulator. This also makes
    // K=1 degenerate cleanly to a pass-through.
    always_comb begin
        cur_mode = at_origin ? mode : mode_q;
        pix_ext  = ACC_W'(in_data);
        acc_sel  = acc_q[win_col];
        if (win_first) begin
            win_val = pix_ext;
        end else if (cur_mode) begin
            win_val = (acc_sel > pix_ext) ? acc_sel : pix_ext;
        end else begin
            win_val = acc_sel + pix_ext;
        end
        win_avg = win_val >>> SHIFT;
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        mode_d       = mode_q;
        acc_d        = acc_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        frame_done_d = 1'b0;
        busy_d       = busy_q;
        if (accept) begin
            acc_d[win_col] = win_val;
            if (at_origin) begin
                mode_d = mode;
            end
            if (col_q == COL_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (win_last) begin
                out_valid_d  = 1'b1;
                out_data_d   = DATA_W'(cur_mode ? win_val : win_avg);
                out_row_d    = win_row;
                out_col_d    = win_col;
                frame_done_d = frame_last;
            end
            busy_d = !frame_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            mode_q       <= 1'b0;
            for (int i = 0; i < OUT_W; i++) begin
                acc_q[i] <= '0;
            end
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            mode_q       <= mode_d;
            acc_q        <= acc_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    // busy also looks at the pixel being accepted at the frame origin. This
    // lets a back-to-back frame keep busy high through the frame_done cycle.
    assign busy       = busy_q || (accept && at_origin && !reset);
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pool2d_stream.sv
// Testbench for pool2d_stream.
// A 4x4 instance covers the directed single-frame, reset and back-to-back
// scenarios. A default 28x28 instance is streamed with a random image and
// random enable/valid gaps, and its output is compared against a bench-side
// pooling model.
module tb_pool2d_stream;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    logic              s_enable = 1'b0;
    logic              s_mode   = 1'b0;
    logic              s_valid  = 1'b0;
    logic signed [7:0] s_data   = '0;
    logic              s_out_valid;
    logic signed [7:0] s_out_data;
    logic [0:0]        s_out_row;
    logic [0:0]        s_out_col;
    logic              s_frame_done;
    logic              s_busy;

    logic              b_enable = 1'b0;
    logic              b_mode   = 1'b0;
    logic              b_valid  = 1'b0;
    logic signed [7:0] b_data   = '0;
    logic              b_out_valid;
    logic signed [7:0] b_out_data;
    logic [3:0]        b_out_row;
    logic [3:0]        b_out_col;
    logic              b_frame_done;
    logic              b_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pool2d_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .K(2)) u_small (
        .clk        (clk),
        .reset      (reset),
        .enable     (s_enable),
        .mode       (s_mode),
        .in_valid   (s_valid),
        .in_data    (s_data),
        .out_valid  (s_out_valid),
        .out_data   (s_out_data),
        .out_row    (s_out_row),
        .out_col    (s_out_col),
        .frame_done (s_frame_done),
        .busy       (s_busy)
    );

    pool2d_stream u_big (
        .clk        (clk),
        .reset      (reset),
        .enable     (b_enable),
        .mode       (b_mode),
        .in_valid   (b_valid),
        .in_data    (b_data),
        .out_valid  (b_out_valid),
        .out_data   (b_out_data),
        .out_row    (b_out_row),
        .out_col    (b_out_col),
        .frame_done (b_frame_done),
        .busy       (b_busy)
    );

    task automatic drive_small(input logic v, input logic [7:0] d, input logic m);
        s_enable = 1'b1;
        s_valid  = v;
        s_data   = d;
        s_mode   = m;
    endtask

    // Reset is held while a pixel is offered; that pixel must be dropped.
    task automatic test_reset();
        reset = 1'b1;
        drive_small(1'b1, 8'd55, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0b want 0", s_out_valid); end
        checks++; if (s_out_data !== 8'sd0) begin errors++; $display("[TB] FAIL reset_out_data got %0d want 0", s_out_data); end
        checks++; if ({s_out_row, s_out_col} !== 2'b00) begin errors++; $display("[TB] FAIL reset_row_col got %0d want 0", {s_out_row, s_out_col}); end
        checks++; if (s_frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done got %0b want 0", s_frame_done); end
        checks++; if (s_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b want 0", s_busy); end
        checks++; if (b_out_valid !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_big got valid %0b busy %0b want 0 0", b_out_valid, b_busy); end
        @(negedge clk);
        reset = 1'b0;
        drive_small(1'b0, 8'd0, 1'b0);
    endtask

    // Three 4x4 frames: 1..16 averaged, 1..16 maxed, and extreme values averaged.
    task automatic test_single_frames();
        logic [7:0] pix  [3][16];
        logic [7:0] want [3][4];
        logic       sel_mode [3];
        string      name [3];
        logic       exp_v;
        logic       exp_fd;
        int         n_out;
        for (int i = 0; i < 16; i++) begin
            pix[0][i] = 8'(i + 1);
            pix[1][i] = 8'(i + 1);
            pix[2][i] = 8'd0;
        end
        pix[2][0]  = 8'hFF; pix[2][1]  = 8'hFE; pix[2][4]  = 8'hFD; pix[2][5]  = 8'hFC;
        pix[2][2]  = 8'h80; pix[2][3]  = 8'h80; pix[2][6]  = 8'h80; pix[2][7]  = 8'h80;
        pix[2][8]  = 8'h7F; pix[2][9]  = 8'h7F; pix[2][12] = 8'h7F; pix[2][13] = 8'h7F;
        want[0] = '{8'd3, 8'd5, 8'd11, 8'd13};
        want[1] = '{8'd6, 8'd8, 8'd14, 8'd16};
        want[2] = '{8'hFD, 8'h80, 8'h7F, 8'h00};
        sel_mode = '{1'b0, 1'b1, 1'b0};
        name     = '{"avg", "max", "extreme"};
        for (int s = 0; s < 3; s++) begin
            n_out = 0;
            for (int i = 0; i <= 16; i++) begin
                @(negedge clk);
                if (i > 0) begin
                    exp_v  = (((i - 1) % 2) == 1) && ((((i - 1) / 4) % 2) == 1);
                    exp_fd = (i == 16);
                    checks++; if (s_out_valid !== exp_v) begin errors++; $display("[TB] FAIL %s_valid after pixel %0d got %0b want %0b", name[s], i - 1, s_out_valid, exp_v); end
                    checks++; if (s_frame_done !== exp_fd) begin errors++; $display("[TB] FAIL %s_frame_done after pixel %0d got %0b want %0b", name[s], i - 1, s_frame_done, exp_fd); end
                    if (exp_v) begin
                        checks++; if (s_out_data !== want[s][n_out]) begin errors++; $display("[TB] FAIL %s_data window %0d got %0d want %0d", name[s], n_out, s_out_data, $signed(want[s][n_out])); end
                        checks++; if ({s_out_row, s_out_col} !== 2'(n_out)) begin errors++; $display("[TB] FAIL %s_row_col window %0d got %0d want %0d", name[s], n_out, {s_out_row, s_out_col}, n_out); end
                        n_out++;
                    end
                end
                if (i < 16) drive_small(1'b1, pix[s][i], sel_mode[s]);
                else        drive_small(1'b0, 8'd0, sel_mode[s]);
            end
        end
    endtask

    // Ten pixels of a frame, then reset together with an offered pixel, then a clean frame.
    task automatic test_reset_mid_frame();
        logic exp_v;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive_small(1'b1, 8'(i + 1), 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        drive_small(1'b1, 8'd99, 1'b0);
        @(negedge clk);
        #1;
        checks++; if (s_out_data !== 8'sd0) begin errors++; $display("[TB] FAIL midreset_data got %0d want 0", s_out_data); end
        checks++; if (s_busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got %0b want 0", s_busy); end
        reset = 1'b0;
        drive_small(1'b0, 8'd0, 1'b0);
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp_v = (((i - 1) % 2) == 1) && ((((i - 1) / 4) % 2) == 1);
                checks++; if (s_out_valid !== exp_v) begin errors++; $display("[TB] FAIL midreset_valid after pixel %0d got %0b want %0b", i - 1, s_out_valid, exp_v); end
                if (i == 6) begin
                    checks++; if (s_out_data !== 8'sd3 || {s_out_row, s_out_col} !== 2'b00) begin errors++; $display("[TB] FAIL midreset_first got %0d at %0d want 3 at 0", s_out_data, {s_out_row, s_out_col}); end
                end
            end
            if (i < 16) drive_small(1'b1, 8'(i + 1), 1'b0);
            else        drive_small(1'b0, 8'd0, 1'b0);
        end
    endtask

    // Two frames with no gap; mode flips to max mid first frame and stays max.
    task automatic test_back_to_back();
        logic [7:0] want [8];
        logic       exp_v;
        logic       exp_fd;
        int         q;
        int         n_out;
        want  = '{8'd3, 8'd5, 8'd11, 8'd13, 8'd6, 8'd8, 8'd14, 8'd16};
        n_out = 0;
        for (int i = 0; i <= 32; i++) begin
            @(negedge clk);
            if (i > 0) begin
                q      = (i - 1) % 16;
                exp_v  = ((q % 2) == 1) && (((q / 4) % 2) == 1);
                exp_fd = (q == 15);
                checks++; if (s_out_valid !== exp_v) begin errors++; $display("[TB] FAIL b2b_valid after pixel %0d got %0b want %0b", i - 1, s_out_valid, exp_v); end
                checks++; if (s_frame_done !== exp_fd) begin errors++; $display("[TB] FAIL b2b_frame_done after pixel %0d got %0b want %0b", i - 1, s_frame_done, exp_fd); end
                if (exp_v) begin
                    checks++; if (s_out_data !== want[n_out]) begin errors++; $display("[TB] FAIL b2b_data output %0d got %0d want %0d", n_out, s_out_data, want[n_out]); end
                    checks++; if ({s_out_row, s_out_col} !== 2'(n_out % 4)) begin errors++; $display("[TB] FAIL b2b_row_col output %0d got %0d want %0d", n_out, {s_out_row, s_out_col}, n_out % 4); end
                    n_out++;
                end
            end
            if (i < 32) begin
                drive_small(1'b1, 8'((i % 16) + 1), (i >= 6));
                #1;
                checks++; if (s_busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy at pixel %0d got %0b want 1", i, s_busy); end
            end else begin
                drive_small(1'b0, 8'd0, 1'b1);
                #1;
                checks++; if (s_busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy_idle got %0b want 0", s_busy); end
            end
        end
    endtask

    // Full 28x28 frame with random enable/valid gaps and random mid-frame mode.
    task automatic test_random_gaps();
        logic signed [7:0] img [784];
        logic [7:0]        golden [196];
        int                sum;
        int                a;
        int                acc_n;
        int                out_n;
        int                fd_n;
        int                cyc;
        logic              prev_emit;
        logic              prev_last;
        logic [7:0]        last_data;
        logic              e;
        logic              v;
        for (int i = 0; i < 784; i++) img[i] = 8'($urandom_range(0, 255));
        img[0] = 8'sh80; img[1] = 8'sh80; img[28] = 8'sh80; img[29] = 8'sh80;
        for (int k = 0; k < 196; k++) begin
            a         = (k / 14) * 56 + (k % 14) * 2;
            sum       = int'(img[a]) + int'(img[a + 1]) + int'(img[a + 28]) + int'(img[a + 29]);
            golden[k] = 8'(sum >>> 2);
        end
        acc_n = 0; out_n = 0; fd_n = 0; cyc = 0;
        prev_emit = 1'b0; prev_last = 1'b0; last_data = 8'd0;
        while ((acc_n < 784 || prev_emit) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            checks++; if (b_out_valid !== prev_emit) begin errors++; $display("[TB] FAIL rand_valid cycle %0d got %0b want %0b", cyc, b_out_valid, prev_emit); end
            checks++; if (b_frame_done !== prev_last) begin errors++; $display("[TB] FAIL rand_frame_done cycle %0d got %0b want %0b", cyc, b_frame_done, prev_last); end
            if (b_frame_done === 1'b1) fd_n++;
            if (prev_emit) begin
                checks++; if (b_out_data !== golden[out_n] || b_out_row !== 4'(out_n / 14) || b_out_col !== 4'(out_n % 14)) begin
                    errors++; $display("[TB] FAIL rand_output %0d got %0d at (%0d,%0d) want %0d at (%0d,%0d)", out_n, b_out_data, b_out_row, b_out_col, $signed(golden[out_n]), out_n / 14, out_n % 14);
                end
                last_data = golden[out_n];
                out_n++;
            end else begin
                checks++; if (b_out_data !== last_data) begin errors++; $display("[TB] FAIL rand_hold cycle %0d got %0d want %0d", cyc, b_out_data, $signed(last_data)); end
            end
            e = 1'($urandom_range(0, 1));
            v = ($urandom_range(0, 3) != 0) && (acc_n < 784);
            b_enable = e;
            b_valid  = v;
            b_data   = (acc_n < 784) ? img[acc_n] : 8'sd0;
            b_mode   = (acc_n == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            prev_emit = e && v && (((acc_n / 28) % 2) == 1) && (((acc_n % 28) % 2) == 1);
            prev_last = e && v && (acc_n == 783);
            if (e && v) acc_n++;
        end
        checks++; if (cyc >= 20000) begin errors++; $display("[TB] FAIL rand_timeout accepted %0d want 784", acc_n); end
        checks++; if (out_n !== 196) begin errors++; $display("[TB] FAIL rand_output_count got %0d want 196", out_n); end
        checks++; if (fd_n !== 1) begin errors++; $display("[TB] FAIL rand_frame_done_count got %0d want 1", fd_n); end
        b_enable = 1'b0;
        b_valid  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_frames();
        test_reset_mid_frame();
        test_back_to_back();
        test_random_gaps();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
